// File: rtl/mem_access_unit_if.sv
// SRAM-like data bus between the MEM-stage load/store engine and the data memory.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  data_req;
  logic                  data_wr;
  logic [1:0]            data_size;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_W-1:0]     data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one bus transaction per load/store, store lane alignment,
// misalignment detection and pipeline stall while a transaction is open.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_Valid,
  input  logic                MEM_Flush,
  input  logic                MEM_Wr,
  input  logic                MEM_IsLoad,
  input  logic                MEM_IsStore,
  input  logic [1:0]          MEM_Size,
  input  logic [31:0]         MEM_ALUOut,
  input  logic [31:0]         MEM_OutB,
  mem_access_unit_if.master   data,
  output logic [31:0]         MEM_DMOut,
  output logic                MEM_AdEL,
  output logic                MEM_AdES,
  output logic                MEM_Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_REQ_K,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t state, state_nx;

  logic                op;
  logic                mis;
  logic                sz_half;
  logic                sz_word;
  logic                issue;
  logic [DATA_W/8-1:0] wstrb_nx;
  logic [DATA_W-1:0]   wdata_nx;

  // Size 3 is illegal and falls through to word handling.
  assign sz_half  = (MEM_Size == 2'd1);
  assign sz_word  = MEM_Size[1];
  assign op       = MEM_Valid & (MEM_IsLoad | MEM_IsStore) & ~MEM_Flush;
  assign mis      = (sz_half & MEM_ALUOut[0]) | (sz_word & (|MEM_ALUOut[1:0]));
  assign MEM_AdEL = op & MEM_IsLoad & mis;
  assign MEM_AdES = op & MEM_IsStore & mis;
  assign issue    = op & ~mis;
  assign MEM_Busy = issue & (state != S_DONE);

  assign data.data_req = (state == S_REQ) || (state == S_REQ_K);

  always_comb begin
    wstrb_nx = '0;
    wdata_nx = MEM_OutB;
    if (MEM_IsStore) begin
      if (MEM_Size == 2'd0) begin
        wdata_nx = {4{MEM_OutB[7:0]}};
        wstrb_nx = 4'b0001 << MEM_ALUOut[1:0];
      end else if (sz_half) begin
        wdata_nx = {2{MEM_OutB[15:0]}};
        wstrb_nx = MEM_ALUOut[1] ? 4'b1100 : 4'b0011;
      end else begin
        wstrb_nx = '1;
      end
    end
  end

  // A flush while the request is still unaccepted keeps req up (REQ_K) and the
  // eventual response is discarded in DRAIN.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (issue) state_nx = S_REQ;
      S_REQ: begin
        if (data.data_addr_ok) state_nx = MEM_Flush ? S_DRAIN : S_WAIT;
        else if (MEM_Flush)    state_nx = S_REQ_K;
      end
      S_REQ_K: if (data.data_addr_ok) state_nx = S_DRAIN;
      S_WAIT: begin
        if (data.data_data_ok) state_nx = MEM_Flush ? S_IDLE : S_DONE;
        else if (MEM_Flush)    state_nx = S_DRAIN;
      end
      S_DONE:  if (MEM_Wr || MEM_Flush) state_nx = S_IDLE;
      S_DRAIN: if (data.data_data_ok) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data.data_wr    <= 1'b0;
      data.data_size  <= '0;
      data.data_addr  <= '0;
      data.data_wstrb <= '0;
      data.data_wdata <= '0;
    end else if (state == S_IDLE && issue) begin
      data.data_wr    <= MEM_IsStore;
      data.data_size  <= MEM_Size;
      data.data_addr  <= MEM_ALUOut[ADDR_W-1:0];
      data.data_wstrb <= wstrb_nx;
      data.data_wdata <= wdata_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MEM_DMOut <= '0;
    end else if (state == S_WAIT && data.data_data_ok && !MEM_Flush && !data.data_wr) begin
      MEM_DMOut <= data.data_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a hand-driven bus slave.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_Valid, MEM_Flush, MEM_Wr, MEM_IsLoad, MEM_IsStore;
  logic [1:0]  MEM_Size;
  logic [31:0] MEM_ALUOut, MEM_OutB;
  logic [31:0] MEM_DMOut;
  logic        MEM_AdEL, MEM_AdES, MEM_Busy;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cycles = 0;
  int base;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .MEM_Valid   (MEM_Valid),
    .MEM_Flush   (MEM_Flush),
    .MEM_Wr      (MEM_Wr),
    .MEM_IsLoad  (MEM_IsLoad),
    .MEM_IsStore (MEM_IsStore),
    .MEM_Size    (MEM_Size),
    .MEM_ALUOut  (MEM_ALUOut),
    .MEM_OutB    (MEM_OutB),
    .data        (bus),
    .MEM_DMOut   (MEM_DMOut),
    .MEM_AdEL    (MEM_AdEL),
    .MEM_AdES    (MEM_AdES),
    .MEM_Busy    (MEM_Busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.data_req === 1'b1) req_cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] b);
    MEM_Valid   = 1'b1;
    MEM_IsLoad  = ld;
    MEM_IsStore = st;
    MEM_Size    = sz;
    MEM_ALUOut  = a;
    MEM_OutB    = b;
  endtask

  task automatic finish_op;
    MEM_Wr = 1'b1;
    step;
    MEM_Wr      = 1'b0;
    MEM_Valid   = 1'b0;
    MEM_IsLoad  = 1'b0;
    MEM_IsStore = 1'b0;
  endtask

  // Zero-wait handshake: addr_ok in the current REQ cycle, data_ok in the first WAIT cycle.
  task automatic complete(input logic [31:0] rd);
    bus.data_addr_ok = 1'b1;
    step;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = rd;
    step;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = '0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    MEM_Valid = 0; MEM_Flush = 0; MEM_Wr = 0; MEM_IsLoad = 0; MEM_IsStore = 0;
    MEM_Size = 0; MEM_ALUOut = 0; MEM_OutB = 0;
    bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   {31'b0, bus.data_req}, 0);
    check("rst_wr",    {31'b0, bus.data_wr}, 0);
    check("rst_size",  {30'b0, bus.data_size}, 0);
    check("rst_addr",  bus.data_addr, 0);
    check("rst_wstrb", {28'b0, bus.data_wstrb}, 0);
    check("rst_wdata", bus.data_wdata, 0);
    check("rst_dmout", MEM_DMOut, 0);
    check("rst_busy",  {31'b0, MEM_Busy}, 0);
    rst = 1'b0;
    step;

    // 1: LW with one-cycle addr_ok and data_ok two cycles after acceptance
    base = req_cycles;
    set_op(1, 0, 2'd2, 32'h8000_0004, 0);
    #1;
    check("t1_busy_idle", {31'b0, MEM_Busy}, 1);
    check("t1_req_idle",  {31'b0, bus.data_req}, 0);
    check("t1_adel",      {31'b0, MEM_AdEL}, 0);
    step;
    check("t1_req",   {31'b0, bus.data_req}, 1);
    check("t1_addr",  bus.data_addr, 32'h8000_0004);
    check("t1_wr",    {31'b0, bus.data_wr}, 0);
    check("t1_size",  {30'b0, bus.data_size}, 2);
    check("t1_wstrb", {28'b0, bus.data_wstrb}, 0);
    bus.data_addr_ok = 1'b1;
    step;
    bus.data_addr_ok = 1'b0;
    #1;
    check("t1_req_wait",  {31'b0, bus.data_req}, 0);
    check("t1_busy_wait", {31'b0, MEM_Busy}, 1);
    step;
    check("t1_busy_wait2", {31'b0, MEM_Busy}, 1);
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'hDEAD_BEEF;
    step;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 0;
    #1;
    check("t1_busy_done", {31'b0, MEM_Busy}, 0);
    check("t1_dmout",     MEM_DMOut, 32'hDEAD_BEEF);
    check("t1_req_count", req_cycles - base, 1);
    step;
    check("t1_done_hold_busy",  {31'b0, MEM_Busy}, 0);
    check("t1_done_hold_dmout", MEM_DMOut, 32'hDEAD_BEEF);
    finish_op;

    // 2: SB and SH lane alignment
    set_op(0, 1, 2'd0, 32'h8000_0003, 32'h0000_00A5);
    #1;
    check("t2_sb_ades", {31'b0, MEM_AdES}, 0);
    check("t2_sb_busy", {31'b0, MEM_Busy}, 1);
    step;
    check("t2_sb_wr",    {31'b0, bus.data_wr}, 1);
    check("t2_sb_wstrb", {28'b0, bus.data_wstrb}, 32'h8);
    check("t2_sb_wdata", bus.data_wdata, 32'hA5A5_A5A5);
    check("t2_sb_size",  {30'b0, bus.data_size}, 0);
    check("t2_sb_addr",  bus.data_addr, 32'h8000_0003);
    complete(32'h0BAD_0BAD);
    check("t2_sb_busy_done", {31'b0, MEM_Busy}, 0);
    check("t2_sb_dmout",     MEM_DMOut, 32'hDEAD_BEEF);
    finish_op;
    set_op(0, 1, 2'd1, 32'h8000_0002, 32'h0000_1234);
    #1;
    step;
    check("t2_sh_wstrb", {28'b0, bus.data_wstrb}, 32'hC);
    check("t2_sh_wdata", bus.data_wdata, 32'h1234_1234);
    check("t2_sh_size",  {30'b0, bus.data_size}, 1);
    complete(0);
    finish_op;

    // 3: misaligned LH and SW
    base = req_cycles;
    set_op(1, 0, 2'd1, 32'h8000_0001, 0);
    #1;
    check("t3_lh_adel", {31'b0, MEM_AdEL}, 1);
    check("t3_lh_ades", {31'b0, MEM_AdES}, 0);
    check("t3_lh_busy", {31'b0, MEM_Busy}, 0);
    step;
    step;
    check("t3_lh_req", {31'b0, bus.data_req}, 0);
    set_op(0, 1, 2'd2, 32'h8000_0002, 32'h5555_5555);
    #1;
    check("t3_sw_ades", {31'b0, MEM_AdES}, 1);
    check("t3_sw_adel", {31'b0, MEM_AdEL}, 0);
    check("t3_sw_busy", {31'b0, MEM_Busy}, 0);
    step;
    check("t3_sw_req", {31'b0, bus.data_req}, 0);
    MEM_Valid = 0; MEM_IsStore = 0;
    step;
    check("t3_req_count", req_cycles - base, 0);

    // 4: flush in WAIT -> DRAIN; following LW waits until after the drained data_ok
    set_op(1, 0, 2'd2, 32'h8000_0010, 0);
    #1;
    step;
    bus.data_addr_ok = 1'b1;
    step;
    bus.data_addr_ok = 1'b0;
    MEM_Flush = 1'b1;
    step;
    MEM_Flush = 1'b0;
    set_op(1, 0, 2'd2, 32'h8000_0020, 0);
    #1;
    check("t4_drain1_req",  {31'b0, bus.data_req}, 0);
    check("t4_drain1_busy", {31'b0, MEM_Busy}, 1);
    step;
    check("t4_drain2_req", {31'b0, bus.data_req}, 0);
    step;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h1111_1111;
    #1;
    check("t4_drain3_req", {31'b0, bus.data_req}, 0);
    step;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 0;
    #1;
    check("t4_idle_req",   {31'b0, bus.data_req}, 0);
    check("t4_idle_busy",  {31'b0, MEM_Busy}, 1);
    check("t4_dmout_kept", MEM_DMOut, 32'hDEAD_BEEF);
    step;
    check("t4_next_req",  {31'b0, bus.data_req}, 1);
    check("t4_next_addr", bus.data_addr, 32'h8000_0020);
    complete(32'h2222_2222);
    check("t4_next_dmout", MEM_DMOut, 32'h2222_2222);
    check("t4_next_busy",  {31'b0, MEM_Busy}, 0);
    finish_op;

    // 5: flush in first REQ cycle, addr_ok on the fourth request cycle
    base = req_cycles;
    set_op(0, 1, 2'd2, 32'h8000_0040, 32'hCAFE_F00D);
    #1;
    step;
    for (int i = 0; i < 4; i++) begin
      MEM_Flush = (i == 0);
      MEM_Valid = (i == 0);
      bus.data_addr_ok = (i == 3);
      #1;
      check($sformatf("t5_req_%0d", i),   {31'b0, bus.data_req}, 1);
      check($sformatf("t5_addr_%0d", i),  bus.data_addr, 32'h8000_0040);
      check($sformatf("t5_wdata_%0d", i), bus.data_wdata, 32'hCAFE_F00D);
      check($sformatf("t5_wstrb_%0d", i), {28'b0, bus.data_wstrb}, 32'hF);
      step;
    end
    MEM_Flush = 1'b0;
    MEM_IsStore = 1'b0;
    bus.data_addr_ok = 1'b0;
    #1;
    check("t5_drain_req",  {31'b0, bus.data_req}, 0);
    check("t5_drain_busy", {31'b0, MEM_Busy}, 0);
    step;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h3333_3333;
    step;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 0;
    #1;
    check("t5_req_count", req_cycles - base, 4);
    check("t5_idle_req",  {31'b0, bus.data_req}, 0);
    check("t5_dmout",     MEM_DMOut, 32'h2222_2222);

    // 6: reset pulse in WAIT, then a normal LW
    set_op(1, 0, 2'd2, 32'h8000_0080, 0);
    #1;
    step;
    bus.data_addr_ok = 1'b1;
    step;
    bus.data_addr_ok = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_req",   {31'b0, bus.data_req}, 0);
    check("t6_rst_dmout", MEM_DMOut, 0);
    check("t6_rst_addr",  bus.data_addr, 0);
    #2;
    rst = 1'b0;
    MEM_ALUOut = 32'h8000_0084;
    step;
    check("t6_req",  {31'b0, bus.data_req}, 1);
    check("t6_addr", bus.data_addr, 32'h8000_0084);
    complete(32'h5A5A_0001);
    check("t6_dmout", MEM_DMOut, 32'h5A5A_0001);
    check("t6_busy",  {31'b0, MEM_Busy}, 0);
    finish_op;
    step;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
